rf_spi_target: RTL and testbench

- SPI target (responder) model of the radio transceiver register interface. It is the far end of the team's radio SPI master.
- Decodes short-address (6-bit) and long-address (10-bit) read and write frames into an internal register file.
- Returns read data on sdo and drives the active-low interrupt line.
- Used as the radio stand-in for block- and system-level simulation, and on FPGA for loopback bring-up without the RF module.

---
 rtl/rf_spi_pkg.sv | 24 ++
 rtl/rf_spi_sync.sv | 43 ++++
 rtl/rf_spi_target.sv | 250 +++++++++++++++++++++++++
 tb/tb_rf_spi_target.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_spi_pkg.sv
// Shared frame constants and state encoding for the radio SPI target model.
package rf_spi_pkg;

  typedef enum logic {
    FrameShort = 1'b0,
    FrameLong  = 1'b1
  } frame_e;

  localparam int unsigned ShortHdrBits = 8;
  localparam int unsigned LongHdrBits  = 12;
  localparam int unsigned DataBits     = 8;

  localparam logic [5:0] DefIntstatAddr = 6'h31;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StPad,
    StDataRd,
    StDataWr,
    StDone
  } state_e;

endpackage

// File: rtl/rf_spi_sync.sv
// Two-flop synchronisers for the SPI pins plus edge pulses in the clk domain.
module rf_spi_sync (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic cs_n,
  input  logic sdi,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic cs_n_s,
  output logic sdi_s
);

  logic [1:0] sck_ff, cs_ff, sdi_ff;
  logic       sck_prev, cs_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      // cs_n clears to 0 so a reset taken mid-frame never sees a fresh frame start.
      sck_ff   <= '0;
      cs_ff    <= '0;
      sdi_ff   <= '0;
      sck_prev <= 1'b0;
      cs_prev  <= 1'b0;
    end else begin
      sck_ff   <= {sck_ff[0], sck};
      cs_ff    <= {cs_ff[0], cs_n};
      sdi_ff   <= {sdi_ff[0], sdi};
      sck_prev <= sck_ff[1];
      cs_prev  <= cs_ff[1];
    end
  end

  assign sck_rise = sck_ff[1] & ~sck_prev;
  assign sck_fall = ~sck_ff[1] & sck_prev;
  assign cs_fall  = ~cs_ff[1] & cs_prev;
  assign cs_rise  = cs_ff[1] & ~cs_prev;
  assign cs_n_s   = cs_ff[1];
  assign sdi_s    = sdi_ff[1];

endmodule

// File: rtl/rf_spi_target.sv
// SPI responder standing in for the radio: short/long register file, clear-on-read
// interrupt status and a commit strobe for every completed write frame.
module rf_spi_target
  import rf_spi_pkg::*;
#(
  parameter int unsigned ShortDepth  = 64,
  parameter int unsigned LongDepth   = 1024,
  parameter logic [5:0]  IntstatAddr = DefIntstatAddr,
  parameter int unsigned LongPad     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       cs_n,
  input  logic       sdi,
  output logic       sdo,
  output logic       sdo_oe,
  output logic       intr_n,
  input  logic [7:0] irq_set,
  output logic       wr_stb,
  output logic       wr_long,
  output logic [9:0] wr_addr,
  output logic [7:0] wr_data
);

  // LongDepth is a power of two, so truncation gives the modulo wrap.
  localparam int unsigned LongAw = $clog2(LongDepth);

  logic sck_rise, sck_fall, cs_fall, cs_rise, cs_n_s, sdi_s;

  rf_spi_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .sck     (sck),
    .cs_n    (cs_n),
    .sdi     (sdi),
    .sck_rise(sck_rise),
    .sck_fall(sck_fall),
    .cs_fall (cs_fall),
    .cs_rise (cs_rise),
    .cs_n_s  (cs_n_s),
    .sdi_s   (sdi_s)
  );

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [10:0] shift_q, shift_d;
  logic [11:0] shift_in;
  logic [9:0]  addr_q, addr_d;
  logic        long_q, long_d;
  logic        write_q, write_d;
  logic        commit;
  logic        rd_load_q, rd_load_d;
  logic [7:0]  rd_shift_q, rd_data;
  logic        sdo_q;
  logic [7:0]  wdata;
  logic [7:0]  intstat_q, intstat_d;
  logic        intstat_hit, intstat_clr, intstat_wr;
  logic        intr_n_q;
  logic        wr_stb_q, wr_long_q;
  logic [9:0]  wr_addr_q;
  logic [7:0]  wr_data_q;

  logic [7:0]           short_q [ShortDepth];
  logic [7:0]           long_mem [LongDepth];
  logic [LongDepth-1:0] long_vld_q;
  logic [7:0]           ram_q;
  logic                 ram_vld_q;
  logic [LongAw-1:0]    wr_idx, rd_idx;

  assign shift_in = {shift_q, sdi_s};
  assign wdata    = shift_in[7:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    long_d  = long_q;
    write_d = write_q;
    commit  = 1'b0;
    if (cs_rise) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cs_fall) begin
            cnt_d   = '0;
            shift_d = '0;
            state_d = StHdr;
          end
        end
        StHdr: begin
          if (sck_rise) begin
            shift_d = shift_in[10:0];
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'(ShortHdrBits - 1) && frame_e'(shift_in[7]) == FrameShort) begin
              addr_d  = {4'b0000, shift_in[6:1]};
              write_d = shift_in[0];
              long_d  = 1'b0;
              cnt_d   = '0;
              state_d = shift_in[0] ? StDataWr : StDataRd;
            end else if (cnt_q == 4'(LongHdrBits - 1)) begin
              addr_d  = shift_in[10:1];
              write_d = shift_in[0];
              long_d  = 1'b1;
              cnt_d   = '0;
              if (LongPad == 0) state_d = shift_in[0] ? StDataWr : StDataRd;
              else              state_d = StPad;
            end
          end
        end
        StPad: begin
          if (sck_rise) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(LongPad - 1)) begin
              cnt_d   = '0;
              state_d = write_q ? StDataWr : StDataRd;
            end
          end
        end
        StDataRd, StDataWr: begin
          if (sck_rise) begin
            shift_d = shift_in[10:0];
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'(DataBits - 1)) begin
              state_d = StDone;
              commit  = (state_q == StDataWr);
            end
          end
        end
        StDone: ;
        default: state_d = StIdle;
      endcase
    end
  end

  assign rd_load_d = (state_d == StDataRd) && (state_q != StDataRd);

  assign intstat_hit = !long_q && (addr_q[5:0] == IntstatAddr);
  assign intstat_clr = rd_load_q && intstat_hit;
  assign intstat_wr  = commit && intstat_hit;

  always_comb begin
    if (long_q)           rd_data = ram_vld_q ? ram_q : 8'h00;
    else if (intstat_hit) rd_data = intstat_q;
    else                  rd_data = short_q[addr_q[5:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      long_q     <= 1'b0;
      write_q    <= 1'b0;
      rd_load_q  <= 1'b0;
      rd_shift_q <= '0;
      sdo_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      long_q    <= long_d;
      write_q   <= write_d;
      rd_load_q <= rd_load_d;
      if (rd_load_q) begin
        rd_shift_q <= rd_data;
        sdo_q      <= 1'b0;
      end else if (state_q == StDataRd && sck_fall) begin
        sdo_q      <= rd_shift_q[7];
        rd_shift_q <= {rd_shift_q[6:0], 1'b0};
      end
    end
  end

  assign sdo_oe = (state_q == StDataRd) && !cs_n_s;
  assign sdo    = sdo_oe & sdo_q;

  // Clear first, then SPI write, then irq_set so coincident interrupts are never lost.
  always_comb begin
    intstat_d = intstat_q;
    if (intstat_clr) intstat_d = 8'h00;
    if (intstat_wr)  intstat_d = wdata;
    intstat_d = intstat_d | irq_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      intstat_q <= '0;
      intr_n_q  <= 1'b1;
    end else begin
      intstat_q <= intstat_d;
      intr_n_q  <= ~|intstat_d;
    end
  end

  assign intr_n = intr_n_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ShortDepth; i++) short_q[i] <= 8'h00;
    end else if (commit && !long_q && !intstat_hit) begin
      short_q[addr_q[5:0]] <= wdata;
    end
  end

  assign wr_idx = addr_q[LongAw-1:0];
  assign rd_idx = addr_d[LongAw-1:0];

  // RAM contents survive reset; the valid vector makes unwritten entries read 0.
  always_ff @(posedge clk) begin
    if (commit && long_q) long_mem[wr_idx] <= wdata;
    ram_q <= long_mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      long_vld_q <= '0;
      ram_vld_q  <= 1'b0;
    end else begin
      if (commit && long_q) long_vld_q[wr_idx] <= 1'b1;
      ram_vld_q <= long_vld_q[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_stb_q  <= 1'b0;
      wr_long_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_stb_q <= commit;
      if (commit) begin
        wr_long_q <= long_q;
        wr_addr_q <= addr_q;
        wr_data_q <= wdata;
      end
    end
  end

  assign wr_stb  = wr_stb_q;
  assign wr_long = wr_long_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_rf_spi_target.sv
// Directed bench for rf_spi_target: drives SPI frames as the master and checks
// strobes, read data, sdo_oe and the interrupt line against hand-derived values.
module tb_rf_spi_target;

  localparam int Half    = 80;
  localparam int LongPad = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0;
  logic       cs_n = 1'b1;
  logic       sdi = 1'b0;
  logic [7:0] irq_set = 8'h00;
  logic       sdo, sdo_oe, intr_n, wr_stb, wr_long;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;

  int n_vec = 0;
  int n_err = 0;

  int         stb_cnt = 0;
  logic       stb_long = 1'b0;
  logic [9:0] stb_addr = '0;
  logic [7:0] stb_data = '0;
  logic       intr_watch = 1'b0;
  logic       intr_glitch = 1'b0;

  logic [7:0] m_short [64];
  logic [7:0] m_long [1024];

  rf_spi_target dut (
    .clk    (clk),
    .rst    (rst),
    .sck    (sck),
    .cs_n   (cs_n),
    .sdi    (sdi),
    .sdo    (sdo),
    .sdo_oe (sdo_oe),
    .intr_n (intr_n),
    .irq_set(irq_set),
    .wr_stb (wr_stb),
    .wr_long(wr_long),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_stb) begin
      stb_cnt  <= stb_cnt + 1;
      stb_long <= wr_long;
      stb_addr <= wr_addr;
      stb_data <= wr_data;
    end
    if (intr_watch && intr_n) intr_glitch <= 1'b1;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic align();
    @(posedge clk);
    #2;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_short[i] = 8'h00;
    for (int i = 0; i < 1024; i++) m_long[i] = 8'h00;
  endtask

  // Master side of one frame; data bits are sampled just before each rise.
  task automatic xfer(input bit is_long, input logic [9:0] addr, input bit wr,
                      input logic [7:0] wd, input int ndata, input int rst_bit,
                      output logic [7:0] rd, output int oe_data, output int oe_hdr);
    logic [23:0] v;
    int nhdr;
    if (is_long) begin
      v    = {1'b1, addr, wr, 4'b1010, wd};
      nhdr = 12 + LongPad;
    end else begin
      v    = {1'b0, addr[5:0], wr, wd, 8'h00};
      nhdr = 8;
    end
    rd      = 8'h00;
    oe_data = 0;
    oe_hdr  = 0;
    cs_n    = 1'b0;
    for (int i = 0; i < nhdr + ndata; i++) begin
      if (i == rst_bit) begin
        align();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        check("rst_mid_oe", sdo_oe, 1'b0);
        check("rst_mid_intr", intr_n, 1'b1);
        check("rst_mid_stb", wr_stb, 1'b0);
      end
      sdi = v[23-i];
      #Half;
      if (i >= nhdr) begin
        rd      = {rd[6:0], sdo};
        oe_data = oe_data + int'(sdo_oe);
      end else begin
        oe_hdr = oe_hdr + int'(sdo_oe);
      end
      sck = 1'b1;
      #Half;
      sck = 1'b0;
    end
    #Half;
    cs_n = 1'b1;
    #(2 * Half);
    oe_hdr = oe_hdr + int'(sdo_oe);
  endtask

  task automatic do_write(input string tag, input bit is_long, input logic [9:0] addr,
                          input logic [7:0] data);
    int s0, oe_d, oe_h;
    logic [7:0] rd;
    s0 = stb_cnt;
    xfer(is_long, addr, 1'b1, data, 8, -1, rd, oe_d, oe_h);
    check({tag, "_stb"}, stb_cnt - s0, 1);
    check({tag, "_long"}, stb_long, is_long);
    check({tag, "_addr"}, stb_addr, addr);
    check({tag, "_data"}, stb_data, data);
    check({tag, "_oe"}, oe_d + oe_h, 0);
    if (is_long) m_long[addr] = data;
    else         m_short[addr[5:0]] = data;
  endtask

  task automatic do_read(input string tag, input bit is_long, input logic [9:0] addr,
                         input logic [7:0] exp);
    int s0, oe_d, oe_h;
    logic [7:0] rd;
    s0 = stb_cnt;
    xfer(is_long, addr, 1'b0, 8'h00, 8, -1, rd, oe_d, oe_h);
    check({tag, "_data"}, rd, exp);
    check({tag, "_oe_data"}, oe_d, 8);
    check({tag, "_oe_other"}, oe_h, 0);
    check({tag, "_no_stb"}, stb_cnt - s0, 0);
  endtask

  initial begin
    int s0, oe_d, oe_h, seen;
    logic [7:0] rd;
    bit is_long, wr;
    logic [9:0] a;
    logic [7:0] d;

    model_clear();
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    align();
    check("rst_sdo", sdo, 1'b0);
    check("rst_sdo_oe", sdo_oe, 1'b0);
    check("rst_intr_n", intr_n, 1'b1);
    check("rst_wr_stb", wr_stb, 1'b0);
    check("rst_wr_long", wr_long, 1'b0);
    check("rst_wr_addr", wr_addr, 10'h000);
    check("rst_wr_data", wr_data, 8'h00);
    repeat (4) align();

    // Short write then read back
    do_write("t1w", 1'b0, 10'h012, 8'hA5);
    do_read("t1r", 1'b0, 10'h012, 8'hA5);

    // Long write then read back; short 0x3F must not alias
    do_write("t2w", 1'b1, 10'h3FF, 8'h5C);
    do_read("t2r", 1'b1, 10'h3FF, 8'h5C);
    do_read("t2s", 1'b0, 10'h03F, 8'h00);

    // Aborted write after 5 data bits
    s0 = stb_cnt;
    xfer(1'b0, 10'h005, 1'b1, 8'hFF, 5, -1, rd, oe_d, oe_h);
    check("t3_no_stb", stb_cnt - s0, 0);
    do_read("t3r", 1'b0, 10'h005, 8'h00);

    // Interrupt set, latency, clear-on-read
    align();
    irq_set = 8'h08;
    align();
    irq_set = 8'h00;
    seen = 0;
    for (int k = 0; k < 3 && seen == 0; k++) begin
      if (intr_n === 1'b0) seen = 1;
      else align();
    end
    check("t4_intr_lat", seen, 1);
    do_read("t4r", 1'b0, 10'h031, 8'h08);
    check("t4_intr_clr", intr_n, 1'b1);

    // irq_set held across the clear: INTSTAT must never drop to zero
    align();
    irq_set = 8'h01;
    repeat (3) align();
    intr_watch = 1'b1;
    do_read("t4c", 1'b0, 10'h031, 8'h01);
    intr_watch = 1'b0;
    irq_set = 8'h00;
    repeat (2) align();
    check("t4_no_glitch", intr_glitch, 1'b0);
    check("t4_intr_held", intr_n, 1'b0);
    do_read("t4d", 1'b0, 10'h031, 8'h01);
    check("t4_intr_clr2", intr_n, 1'b1);

    // Reset in the pad bits of a long write
    do_write("t5w", 1'b0, 10'h000, 8'h77);
    align();
    irq_set = 8'h80;
    align();
    irq_set = 8'h00;
    repeat (2) align();
    check("t5_intr_pre", intr_n, 1'b0);
    s0 = stb_cnt;
    xfer(1'b1, 10'h155, 1'b1, 8'h99, 8, 14, rd, oe_d, oe_h);
    model_clear();
    check("t5_no_stb", stb_cnt - s0, 0);
    check("t5_intr_post", intr_n, 1'b1);
    check("t5_oe_post", sdo_oe, 1'b0);
    do_read("t5s", 1'b0, 10'h000, 8'h00);
    do_read("t5l", 1'b1, 10'h3FF, 8'h00);
    do_read("t5p", 1'b1, 10'h155, 8'h00);

    // Back-to-back mixed frames against the reference model
    for (int k = 0; k < 20; k++) begin
      is_long = 1'($urandom_range(0, 1));
      wr      = 1'($urandom_range(0, 1));
      if (k < 4) wr = 1'b1;
      if (is_long) a = 10'($urandom_range(0, 1023));
      else begin
        a = 10'($urandom_range(0, 63));
        if (a == 10'h031) a = 10'h030;
      end
      // Bias reads towards locations written earlier in this loop
      if (!wr && k % 2 == 0) a = is_long ? 10'h2A0 : 10'h011;
      if (k == 1) begin is_long = 1'b1; a = 10'h2A0; end
      if (k == 2) begin is_long = 1'b0; a = 10'h011; end
      d = 8'($urandom_range(0, 255));
      if (wr) do_write($sformatf("t6w%0d", k), is_long, a, d);
      else    do_read($sformatf("t6r%0d", k), is_long, a, is_long ? m_long[a] : m_short[a[5:0]]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
